// File: rtl/noc_rr_arbiter.sv
// noc_rr_arbiter: round-robin output-port arbiter for the NoC router.
// Arbitrates NUM_PORTS level-sensitive requests for one output channel,
// drives the one-hot crossbar select and handshakes downstream via RTS/DCTS.
// The current port keeps the channel while it requests (sticky service).
// Optional build macro ARB_HOLD_LIMIT_EN: forces rotation after MAX_HOLD
// consecutive grants to one port when another port is waiting.
module noc_rr_arbiter #(
    parameter int unsigned NUM_PORTS = 5,
    parameter int unsigned MAX_HOLD  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_PORTS-1:0] req,
    input  logic                 dcts,
    output logic [NUM_PORTS-1:0] grant,
    output logic [NUM_PORTS-1:0] xbar_sel,
    output logic                 rts,
    output logic                 busy
);

    localparam int unsigned IW       = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int unsigned SW       = NUM_PORTS + 1;
    localparam int unsigned HW       = 8;
    localparam logic [HW-1:0] HOLD_MAX_CNT = HW'(255);

    // Reject out-of-range hold limits at elaboration
    if (MAX_HOLD < 1 || MAX_HOLD > 255) begin : g_bad_max_hold
        $error("noc_rr_arbiter: MAX_HOLD must be in 1..255");
    end

    // One-hot state: bit 0 = IDLE, bit i+1 = SERVE_i
    localparam logic [SW-1:0] ST_IDLE = SW'(1);

    logic [SW-1:0]        state_q,    state_d;
    logic                 rts_q,      rts_d;
    logic [IW-1:0]        last_q,     last_d;
    logic [HW-1:0]        hold_cnt_q, hold_cnt_d;

    logic [NUM_PORTS-1:0] serve_vec;
    logic                 is_idle;
    logic [IW-1:0]        cur_idx;
    logic [IW-1:0]        start_idx;
    logic [IW-1:0]        pick;
    logic                 found;
    logic                 grant_any;
    logic                 hold_hit;
    logic                 sticky;
    logic                 stall;
    logic [SW-1:0]        nxt;
    logic [IW-1:0]        next_idx;

    assign serve_vec = state_q[SW-1:1];
    assign is_idle   = state_q[0];
    assign grant_any = rts_q & dcts & ~is_idle;
    assign stall     = rts_q & ~dcts;

    // Index of the port currently being served
    always_comb begin
        cur_idx = '0;
        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (serve_vec[i]) cur_idx = IW'(i);
        end
    end

    // Circular scan starting one past the last/current port, that port last
    always_comb begin
        found     = 1'b0;
        pick      = '0;
        start_idx = is_idle ? last_q : cur_idx;
        for (int unsigned off = 1; off <= NUM_PORTS; off++) begin
            int unsigned p;
            p = (32'(start_idx) + off) % NUM_PORTS;
            if (!found && req[IW'(p)]) begin
                found = 1'b1;
                pick  = IW'(p);
            end
        end
    end

    // Hold-limit override of the sticky rule
`ifdef ARB_HOLD_LIMIT_EN
    always_comb begin
        hold_hit = 1'b0;
        // >= keeps rotation guaranteed even after hold_cnt ran past the limit
        if (grant_any && (hold_cnt_q >= HW'(MAX_HOLD - 1)) && |(req & ~serve_vec)) begin
            hold_hit = 1'b1;
        end
    end
`else
    assign hold_hit = 1'b0;
`endif

    // Next-state, last-served, RTS and hold counter
    always_comb begin
        sticky     = 1'b0;
        nxt        = ST_IDLE;
        state_d    = state_q;
        rts_d      = 1'b0;
        last_d     = last_q;
        hold_cnt_d = hold_cnt_q;
        next_idx   = '0;

        sticky = ~is_idle & req[cur_idx] & ~hold_hit;
        if (sticky) begin
            nxt = state_q;
        end else if (found) begin
            nxt = SW'(1) << (32'(pick) + 1);
        end else begin
            nxt = ST_IDLE;
        end

        // A pending flit under back-pressure pins the state
        state_d = stall ? state_q : nxt;

        for (int unsigned i = 0; i < NUM_PORTS; i++) begin
            if (state_d[i+1]) next_idx = IW'(i);
        end
        if (!state_d[0]) last_d = next_idx;

        // RTS alternates per flit; never raised while idle or about to go idle
        if (is_idle || state_d[0]) begin
            rts_d = 1'b0;
        end else if (rts_q && dcts) begin
            rts_d = 1'b0;
        end else begin
            rts_d = 1'b1;
        end

        if (state_d != state_q || is_idle) begin
            hold_cnt_d = '0;
        end else if (grant_any && hold_cnt_q != HOLD_MAX_CNT) begin
            hold_cnt_d = hold_cnt_q + HW'(1);
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            rts_q      <= 1'b0;
            last_q     <= IW'(NUM_PORTS - 1);
            hold_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            rts_q      <= rts_d;
            last_q     <= last_d;
            hold_cnt_q <= hold_cnt_d;
        end
    end

    assign grant    = serve_vec & {NUM_PORTS{rts_q & dcts}};
    assign xbar_sel = serve_vec;
    assign rts      = rts_q;
    assign busy     = ~is_idle;

endmodule

// File: tb/tb_noc_rr_arbiter.sv
// tb_noc_rr_arbiter: directed bench for noc_rr_arbiter (NUM_PORTS=5, MAX_HOLD=3).
// Build with +define+ARB_HOLD_LIMIT_EN to exercise the hold-limit rotation.
module tb_noc_rr_arbiter;

    localparam int unsigned NP = 5;

    logic          clk;
    logic          rst;
    logic [NP-1:0] req;
    logic          dcts;
    logic [NP-1:0] grant;
    logic [NP-1:0] xbar_sel;
    logic          rts;
    logic          busy;

    int n_checks = 0;
    int n_pass   = 0;

    noc_rr_arbiter #(.NUM_PORTS(NP), .MAX_HOLD(3)) dut (
        .clk      (clk),
        .rst      (rst),
        .req      (req),
        .dcts     (dcts),
        .grant    (grant),
        .xbar_sel (xbar_sel),
        .rts      (rts),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Advance one clock; sample point sits 2 time units after the edge
    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic do_reset();
        rst  = 1'b1;
        req  = '0;
        dcts = 1'b1;
        step();
        step();
        rst  = 1'b0;
    endtask

    function automatic int onehot_idx(input logic [NP-1:0] v);
        int r = -1;
        for (int i = 0; i < NP; i++) if (v[i]) r = i;
        return r;
    endfunction

    initial begin
        int q[$];
        int exp_hold[9];
        int cnt;
        logic ok;

        rst = 1'b1; req = '0; dcts = 1'b1;

        // Reset with all ports requesting
        req = 5'b11111;
        step();
        check("rst_grant", 32'(grant), 32'h0);
        check("rst_xbar",  32'(xbar_sel), 32'h0);
        check("rst_rts",   32'(rts), 32'h0);
        check("rst_busy",  32'(busy), 32'h0);
        step();
        check("rst2_xbar", 32'(xbar_sel), 32'h0);
        rst = 1'b0;
        step();
        check("first_port0", 32'(xbar_sel), 32'h01);

        // Single request on port 4
        do_reset();
        req = 5'b10000;
        step();
        check("single_c1_xbar",  32'(xbar_sel), 32'h10);
        check("single_c1_rts",   32'(rts), 32'h0);
        check("single_c1_grant", 32'(grant), 32'h0);
        step();
        check("single_c2_rts",   32'(rts), 32'h1);
        check("single_c2_grant", 32'(grant), 32'h10);
        step();
        check("single_c3_rts",   32'(rts), 32'h0);
        check("single_c3_grant", 32'(grant), 32'h0);
        cnt = 0; ok = 1'b1;
        for (int i = 0; i < 8; i++) begin
            step();
            if (grant == 5'b10000) cnt++;
            else if (grant != '0) ok = 1'b0;
            if (xbar_sel != 5'b10000) ok = 1'b0;
        end
        check("single_rate",   32'(cnt), 32'd4);
        check("single_stable", 32'(ok), 32'h1);

        // Back-pressure on port 2
        do_reset();
        dcts = 1'b0;
        req  = 5'b00100;
        step();
        step();
        check("bp_rts_up", 32'(rts), 32'h1);
        cnt = 0; ok = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step();
            if (rts !== 1'b1 || grant !== '0 || xbar_sel !== 5'b00100) ok = 1'b0;
        end
        check("bp_hold", 32'(ok), 32'h1);
        dcts = 1'b1;
        #1;
        check("bp_release_grant", 32'(grant), 32'h04);
        if (grant != '0) cnt++;
        step();
        dcts = 1'b0;
        #1;
        for (int i = 0; i < 4; i++) begin
            if (grant != '0) cnt++;
            step();
        end
        check("bp_one_pulse", 32'(cnt), 32'd1);

        // Round-robin with each port dropping after one grant
        do_reset();
        req = 5'b01011;
        q.delete();
        for (int i = 0; i < 40 && (req != '0 || busy); i++) begin
            step();
            if (grant != '0) begin
                q.push_back(onehot_idx(grant));
                req = req & ~grant;
            end
        end
        check("rr_count", 32'(q.size()), 32'd3);
        if (q.size() == 3) begin
            check("rr_first",  32'(q[0]), 32'd0);
            check("rr_second", 32'(q[1]), 32'd1);
            check("rr_third",  32'(q[2]), 32'd3);
        end
        check("rr_idle", 32'(busy), 32'h0);
        check("rr_last", 32'(dut.last_q), 32'd3);

        // Hold limit with ports 0 and 1 requesting constantly
`ifdef ARB_HOLD_LIMIT_EN
        exp_hold = '{0, 0, 0, 1, 1, 1, 0, 0, 0};
`else
        exp_hold = '{0, 0, 0, 0, 0, 0, 0, 0, 0};
`endif
        do_reset();
        req = 5'b00011;
        q.delete();
        for (int i = 0; i < 80 && q.size() < 9; i++) begin
            step();
            if (grant != '0) q.push_back(onehot_idx(grant));
        end
        check("hold_count", 32'(q.size()), 32'd9);
        ok = 1'b1;
        for (int i = 0; i < q.size() && i < 9; i++) if (q[i] != exp_hold[i]) ok = 1'b0;
        check("hold_sequence", 32'(ok), 32'h1);

        // Reset during a pending flit in SERVE_3
        do_reset();
        req = 5'b01000;
        repeat (6) step();
        dcts = 1'b0;
        for (int i = 0; i < 10 && !rts; i++) step();
        check("mid_pre_rts",  32'(rts), 32'h1);
        check("mid_pre_xbar", 32'(xbar_sel), 32'h08);
        check("mid_pre_hold", 32'(dut.hold_cnt_q != 0), 32'h1);
        rst = 1'b1;
        step();
        check("mid_state", 32'(dut.state_q), 32'h01);
        check("mid_rts",   32'(rts), 32'h0);
        check("mid_grant", 32'(grant), 32'h0);
        check("mid_hold",  32'(dut.hold_cnt_q), 32'h0);
        check("mid_busy",  32'(busy), 32'h0);
        rst = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
